rst_seq: RTL and testbench

- Reset sequencer that generates the reset requests consumed by the design's reset synchronisers.
- Combines an asynchronous board push-button and an asynchronous MMCM/PLL `locked` flag into one fault condition.
- Holds reset for a minimum time after the fault clears, then releases per-domain reset outputs one stage at a time, in order.
- Sits at the top of the HDMI design on the free-running board clock, ahead of the per-domain reset bridges.

---
 rtl/rst_seq_if.sv | 27 ++
 rtl/rst_seq.sv | 138 +++++++++++++
 tb/tb_rst_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Reset sequencer signal bundle: async fault inputs in,
// staged reset requests and status out.
interface rst_seq_if #(
    parameter int N = 3
);
    logic         i_btn;
    logic         i_locked;
    logic [N-1:0] o_rst;
    logic         o_ready;
    logic [7:0]   o_evt_cnt;

    modport master (
        output i_btn,
        output i_locked,
        input  o_rst,
        input  o_ready,
        input  o_evt_cnt
    );

    modport slave (
        input  i_btn,
        input  i_locked,
        output o_rst,
        output o_ready,
        output o_evt_cnt
    );
endinterface

// File: rtl/rst_seq.sv
// Board-level reset sequencer: merges button and PLL lock into one
// fault, holds reset, then releases per-domain resets in order.
module rst_seq #(
    parameter logic P_BTN_POLARITY    = 1'b1,
    parameter logic P_SRST_POLARITY   = 1'b1,
    parameter int   P_NUM_STAGES      = 3,
    parameter int   P_DEBOUNCE_CYCLES = 1024,
    parameter int   P_HOLD_CYCLES     = 16,
    parameter int   P_STAGE_GAP       = 4
) (
    input logic       i_sclk,
    input logic       i_srst,
    rst_seq_if.slave  bus
);

    localparam int DBW  = $clog2(P_DEBOUNCE_CYCLES);
    localparam int CMAX = (P_HOLD_CYCLES > P_STAGE_GAP) ?
                          P_HOLD_CYCLES : P_STAGE_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = (P_NUM_STAGES > 1) ? $clog2(P_NUM_STAGES) : 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(P_DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(P_HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(P_STAGE_GAP - 1);
    localparam logic [SW-1:0]  STG_LAST  = SW'(P_NUM_STAGES - 1);

    localparam logic [P_NUM_STAGES-1:0] RST_ON =
        {P_NUM_STAGES{P_SRST_POLARITY}};

    typedef enum logic [1:0] {
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    logic [1:0]              btn_ff;
    logic [1:0]              lck_ff;
    logic                    btn_db;
    logic [DBW-1:0]          db_cnt;
    logic                    fault;
    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           stage;
    logic [P_NUM_STAGES-1:0] rst_q;
    logic                    ready_q;
    logic [7:0]              evt_q;

    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            btn_ff <= {2{~P_BTN_POLARITY}};
            lck_ff <= 2'b00;
        end else begin
            btn_ff <= {btn_ff[0], bus.i_btn};
            lck_ff <= {lck_ff[0], bus.i_locked};
        end
    end

    // The debounced level flips on the Nth consecutive differing cycle.
    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            btn_db <= ~P_BTN_POLARITY;
            db_cnt <= '0;
        end else if (btn_ff[1] == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_ff[1];
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign fault = (btn_db == P_BTN_POLARITY) | ~lck_ff[1];

    // A fault overrides every state: all stages re-assert at once.
    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            stage   <= '0;
            rst_q   <= RST_ON;
            ready_q <= 1'b0;
            evt_q   <= 8'd0;
        end else if (fault) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            stage   <= '0;
            rst_q   <= RST_ON;
            ready_q <= 1'b0;
            if (state == S_RUN && evt_q != 8'hFF)
                evt_q <= evt_q + 8'd1;
        end else begin
            case (state)
                S_ASSERT: begin
                    rst_q   <= RST_ON;
                    ready_q <= 1'b0;
                    state   <= S_HOLD;
                    cnt     <= '0;
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                        stage <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        rst_q[stage] <= ~P_SRST_POLARITY;
                        cnt          <= '0;
                        if (stage == STG_LAST) begin
                            state   <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            stage <= stage + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= S_ASSERT;
                end
            endcase
        end
    end

    assign bus.o_rst     = rst_q;
    assign bus.o_ready   = ready_q;
    assign bus.o_evt_cnt = evt_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues timed output changes,
// a negedge monitor compares every observed change against the queue.
module tb_rst_seq;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic [7:0] evt;
    } exp_t;

    logic  clk = 1'b0;
    logic  srst = 1'b1;
    int    ecnt = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    exp_t  q[$];

    rst_seq_if #(.N(3)) bus ();

    rst_seq dut (
        .i_sclk (clk),
        .i_srst (srst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        ecnt++;
    end

    function automatic void push(int cyc, logic [2:0] r,
                                 logic y, logic [7:0] e);
        exp_t x;
        x.cyc = cyc;
        x.rst = r;
        x.rdy = y;
        x.evt = e;
        q.push_back(x);
    endfunction

    initial begin : monitor
        logic [11:0] last;
        logic [11:0] cur;
        exp_t        e;
        wait (mon_en);
        last = {bus.o_rst, bus.o_ready, bus.o_evt_cnt};
        forever begin
            @(negedge clk);
            cur = {bus.o_rst, bus.o_ready, bus.o_evt_cnt};
            if (cur !== last) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change edge %0d got %h", ecnt, cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== {e.rst, e.rdy, e.evt} || ecnt != e.cyc) begin
                        n_fail++;
                        $display("FAIL change edge %0d got %h, required %h at edge %0d",
                                 ecnt, cur, {e.rst, e.rdy, e.evt}, e.cyc);
                    end
                end
                last = cur;
            end
        end
    end

    task automatic chk(string name, logic [11:0] exp);
        logic [11:0] got;
        got = {bus.o_rst, bus.o_ready, bus.o_evt_cnt};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic drain(string name, int bound);
        int k;
        k = 0;
        while (q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout, %0d changes missing, required 0",
                     name, q.size());
            q.delete();
        end
    endtask

    initial begin : stim
        int e0;
        int c;
        bus.i_btn    = 1'b0;
        bus.i_locked = 1'b0;
        srst         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_state", {3'b111, 1'b0, 8'd0});
        end
        srst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("unlocked_hold", {3'b111, 1'b0, 8'd0});
        end
        mon_en = 1'b1;
        @(negedge clk);

        // first lock: releases at edges 23, 27, 31
        e0 = ecnt;
        bus.i_locked = 1'b1;
        push(e0 + 23, 3'b110, 1'b0, 8'd0);
        push(e0 + 27, 3'b100, 1'b0, 8'd0);
        push(e0 + 31, 3'b000, 1'b1, 8'd0);
        drain("first_release", 60);

        // single-cycle lock drop in RUN
        e0 = ecnt;
        bus.i_locked = 1'b0;
        @(negedge clk);
        bus.i_locked = 1'b1;
        push(e0 + 3,  3'b111, 1'b0, 8'd1);
        push(e0 + 24, 3'b110, 1'b0, 8'd1);
        push(e0 + 28, 3'b100, 1'b0, 8'd1);
        push(e0 + 32, 3'b000, 1'b1, 8'd1);
        drain("lock_glitch", 60);

        // 1023-cycle press is filtered
        bus.i_btn = 1'b1;
        repeat (1023) @(negedge clk);
        bus.i_btn = 1'b0;
        repeat (1100) @(negedge clk);
        chk("short_press", {3'b000, 1'b1, 8'd1});

        // 1030-cycle press resets until debounced release
        e0 = ecnt;
        bus.i_btn = 1'b1;
        push(e0 + 1027, 3'b111, 1'b0, 8'd2);
        push(e0 + 2077, 3'b110, 1'b0, 8'd2);
        push(e0 + 2081, 3'b100, 1'b0, 8'd2);
        push(e0 + 2085, 3'b000, 1'b1, 8'd2);
        repeat (1030) @(negedge clk);
        bus.i_btn = 1'b0;
        drain("long_press", 1200);

        // fault during RELEASE after stage 0 released
        e0 = ecnt;
        bus.i_locked = 1'b0;
        push(e0 + 3, 3'b111, 1'b0, 8'd3);
        repeat (5) @(negedge clk);
        bus.i_locked = 1'b1;
        push(e0 + 28, 3'b110, 1'b0, 8'd3);
        repeat (24) @(negedge clk);
        bus.i_locked = 1'b0;
        push(e0 + 32, 3'b111, 1'b0, 8'd3);
        repeat (6) @(negedge clk);
        bus.i_locked = 1'b1;
        push(e0 + 58, 3'b110, 1'b0, 8'd3);
        push(e0 + 62, 3'b100, 1'b0, 8'd3);
        push(e0 + 66, 3'b000, 1'b1, 8'd3);
        drain("release_abort", 80);

        // event counter saturation
        for (int i = 0; i < 260; i++) begin
            c = (4 + i > 255) ? 255 : 4 + i;
            e0 = ecnt;
            bus.i_locked = 1'b0;
            @(negedge clk);
            bus.i_locked = 1'b1;
            push(e0 + 3,  3'b111, 1'b0, 8'(c));
            push(e0 + 24, 3'b110, 1'b0, 8'(c));
            push(e0 + 28, 3'b100, 1'b0, 8'(c));
            push(e0 + 32, 3'b000, 1'b1, 8'(c));
            drain("evt_loop", 60);
        end
        chk("evt_saturated", {3'b000, 1'b1, 8'd255});

        // synchronous reset in the middle of HOLD
        e0 = ecnt;
        bus.i_locked = 1'b0;
        push(e0 + 3, 3'b111, 1'b0, 8'd255);
        repeat (5) @(negedge clk);
        bus.i_locked = 1'b1;
        repeat (7) @(negedge clk);
        srst = 1'b1;
        push(e0 + 13, 3'b111, 1'b0, 8'd0);
        @(negedge clk);
        srst = 1'b0;
        push(e0 + 36, 3'b110, 1'b0, 8'd0);
        push(e0 + 40, 3'b100, 1'b0, 8'd0);
        push(e0 + 44, 3'b000, 1'b1, 8'd0);
        drain("srst_in_hold", 60);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
